sap1_control_unit: RTL and testbench

- Standalone micro-sequencer for the 8-bit SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A/B registers, ALU, flags and output register.
- Owns the instruction step counter and the halt state, and decodes the control word that drives bus sources and register loads.
- Adds variable-length instructions and an optional single-step mode, so the datapath becomes a pure slave of the `ctrl` bus.

---
 rtl/sap1_control_unit_pkg.sv | 50 +++++
 rtl/sap1_control_unit_if.sv | 23 ++
 rtl/sap1_control_unit_microcode_rom.sv | 92 +++++++++
 rtl/sap1_control_unit.sv | 59 +++++
 tb/tb_sap1_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sap1_control_unit_pkg.sv
// Shared opcode, control-bit and micro-step definitions for the SAP-1 sequencer.
// Pure constants and a length decoder; no state, no handshake.
package sap1_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CB_HLT = 15;
  localparam int CB_MI  = 14;
  localparam int CB_RI  = 13;
  localparam int CB_RO  = 12;
  localparam int CB_IO  = 11;
  localparam int CB_II  = 10;
  localparam int CB_AI  = 9;
  localparam int CB_AO  = 8;
  localparam int CB_EO  = 7;
  localparam int CB_SU  = 6;
  localparam int CB_BI  = 5;
  localparam int CB_OI  = 4;
  localparam int CB_CE  = 3;
  localparam int CB_CO  = 2;
  localparam int CB_J   = 1;
  localparam int CB_FI  = 0;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  // Total micro-steps including the two fetch steps.
  function automatic logic [2:0] instr_len(input logic [3:0] op);
    case (op)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: instr_len = 3'd3;
      OP_LDA, OP_STA:                               instr_len = 3'd4;
      OP_ADD, OP_SUB:                               instr_len = 3'd5;
      default:                                      instr_len = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/sap1_control_unit_if.sv
// Bundle between the sequencer and the SAP-1 datapath; master = sequencer side.
// Combinational control word; no flow control beyond the single-step input.
interface sap1_control_unit_if #(parameter int OP_W = 4);
  logic [OP_W-1:0] ir_op;
  logic            flag_c;
  logic            flag_z;
  logic            step_mode;
  logic            step;
  logic [15:0]     ctrl;
  logic [2:0]      stage;
  logic            halted;
  logic            instr_done;

  modport master (
    input  ir_op, flag_c, flag_z, step_mode, step,
    output ctrl, stage, halted, instr_done
  );

  modport slave (
    output ir_op, flag_c, flag_z, step_mode, step,
    input  ctrl, stage, halted, instr_done
  );
endinterface

// File: rtl/sap1_control_unit_microcode_rom.sv
// Combinational microcode: (stage, opcode, flags) -> control word and last-step flag.
// Zero latency; no backpressure, gating by the sequencer is applied outside.
import sap1_pkg::*;

module sap1_microcode_rom #(
  parameter int OP_W = 4
) (
  input  logic [2:0]      stage,
  input  logic [OP_W-1:0] ir_op,
  input  logic            flag_c,
  input  logic            flag_z,
  output logic [15:0]     ctrl,
  output logic            last_step
);
  logic [3:0] op;
  assign op = ir_op[3:0];

  always_comb begin
    ctrl = '0;
    case (stage)
      T0: begin
        ctrl[CB_CO] = 1'b1;
        ctrl[CB_MI] = 1'b1;
      end
      T1: begin
        ctrl[CB_RO] = 1'b1;
        ctrl[CB_II] = 1'b1;
        ctrl[CB_CE] = 1'b1;
      end
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl[CB_IO] = 1'b1;
            ctrl[CB_MI] = 1'b1;
          end
          OP_LDI: begin
            ctrl[CB_IO] = 1'b1;
            ctrl[CB_AI] = 1'b1;
          end
          OP_JMP: begin
            ctrl[CB_IO] = 1'b1;
            ctrl[CB_J]  = 1'b1;
          end
          // Conditional jumps still drive IO so the bus is defined when not taken.
          OP_JC: begin
            ctrl[CB_IO] = 1'b1;
            ctrl[CB_J]  = flag_c;
          end
          OP_JZ: begin
            ctrl[CB_IO] = 1'b1;
            ctrl[CB_J]  = flag_z;
          end
          OP_OUT: begin
            ctrl[CB_AO] = 1'b1;
            ctrl[CB_OI] = 1'b1;
          end
          OP_HLT:  ctrl[CB_HLT] = 1'b1;
          default: ctrl = '0;
        endcase
      end
      T3: begin
        case (op)
          OP_LDA: begin
            ctrl[CB_RO] = 1'b1;
            ctrl[CB_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[CB_RO] = 1'b1;
            ctrl[CB_BI] = 1'b1;
          end
          OP_STA: begin
            ctrl[CB_AO] = 1'b1;
            ctrl[CB_RI] = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      T4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ctrl[CB_EO] = 1'b1;
          ctrl[CB_AI] = 1'b1;
          ctrl[CB_FI] = 1'b1;
          ctrl[CB_SU] = (op == OP_SUB);
        end
      end
      default: ctrl = '0;
    endcase
  end

  assign last_step = (stage == (instr_len(op) - 3'd1));

endmodule

// File: rtl/sap1_control_unit.sv
// SAP-1 micro-sequencer: step counter, halt state and single-step gating of the control word.
// Control word is combinational from registered stage; a stalled or halted cycle issues nothing.
import sap1_pkg::*;

module sap1_control_unit #(
  parameter int SINGLE_STEP_EN = 1,
  parameter int OP_W           = 4
) (
  input  logic                clk,
  input  logic                reset,
  sap1_control_unit_if.master bus
);
  logic [2:0]  stage_q;
  logic        halted_q;
  logic        step_q;
  logic [15:0] rom_ctrl;
  logic        rom_last;
  logic        step_gate;
  logic        adv;

  sap1_microcode_rom #(.OP_W(OP_W)) u_rom (
    .stage     (stage_q),
    .ir_op     (bus.ir_op),
    .flag_c    (bus.flag_c),
    .flag_z    (bus.flag_z),
    .ctrl      (rom_ctrl),
    .last_step (rom_last)
  );

  // Reset is folded into adv so nothing leaks onto the bus while reset is held.
  assign step_gate = (SINGLE_STEP_EN != 0) && bus.step_mode;
  assign adv       = reset && !halted_q && (!step_gate || (bus.step && !step_q));

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q  <= T0;
      halted_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      step_q <= bus.step;
      if (adv) begin
        if (rom_ctrl[CB_HLT]) begin
          halted_q <= 1'b1;
          stage_q  <= T0;
        end else if (rom_last) begin
          stage_q <= T0;
        end else begin
          stage_q <= stage_q + 3'd1;
        end
      end
    end
  end

  assign bus.ctrl       = adv ? rom_ctrl : 16'h0000;
  assign bus.instr_done = adv && rom_last;
  assign bus.stage      = stage_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_sap1_control_unit.sv
// Directed bench for sap1_control_unit: inputs change and outputs are checked on the falling edge.
module tb_sap1_control_unit;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  sap1_control_unit_if #(.OP_W(4)) bus ();

  sap1_control_unit #(.SINGLE_STEP_EN(1), .OP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset         = 1'b0;
    bus.ir_op     = 4'h0;
    bus.flag_c    = 1'b0;
    bus.flag_z    = 1'b0;
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.ctrl !== 16'h0000) begin
        bad++;
        $display("FAIL reset_ctrl cyc%0d: got %h want 0000", i, bus.ctrl);
      end
      total++;
      if (bus.stage !== 3'd0 || bus.halted !== 1'b0 || bus.instr_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state cyc%0d: stage=%0d halted=%b done=%b want 0/0/0",
                 i, bus.stage, bus.halted, bus.instr_done);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus.stage !== 3'd0 || bus.ctrl !== 16'h4004) begin
      bad++;
      $display("FAIL release_t0: stage=%0d ctrl=%h want 0/4004", bus.stage, bus.ctrl);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd1 || bus.ctrl !== 16'h1408) begin
      bad++;
      $display("FAIL release_t1: stage=%0d ctrl=%h want 1/1408", bus.stage, bus.ctrl);
    end
    total++;
    if (bus.instr_done !== 1'b1) begin
      bad++;
      $display("FAIL nop_done_t1: got %b want 1", bus.instr_done);
    end
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [15:0] exp_c [5];
    for (int k = 0; k < 2; k++) begin
      bus.ir_op = (k == 0) ? 4'h2 : 4'h3;
      exp_c[0] = 16'h4004;
      exp_c[1] = 16'h1408;
      exp_c[2] = 16'h4800;
      exp_c[3] = 16'h1020;
      exp_c[4] = (k == 0) ? 16'h0281 : 16'h02C1;
      for (int i = 0; i < 5; i++) begin
        #1;
        total++;
        if (bus.stage !== 3'(i)) begin
          bad++;
          $display("FAIL alu%0d_stage t%0d: got %0d want %0d", k, i, bus.stage, i);
        end
        total++;
        if (bus.ctrl !== exp_c[i]) begin
          bad++;
          $display("FAIL alu%0d_ctrl t%0d: got %h want %h", k, i, bus.ctrl, exp_c[i]);
        end
        total++;
        if (bus.instr_done !== 1'(i == 4)) begin
          bad++;
          $display("FAIL alu%0d_done t%0d: got %b want %b", k, i, bus.instr_done, (i == 4));
        end
        @(negedge clk);
      end
      #1;
      total++;
      if (bus.stage !== 3'd0) begin
        bad++;
        $display("FAIL alu%0d_wrap: stage=%0d want 0", k, bus.stage);
      end
    end
  endtask

  task automatic test_jumps();
    logic [3:0]  ops   [4];
    logic        cs    [4];
    logic        zs    [4];
    logic [15:0] exp_c [4];
    ops[0] = 4'h7; cs[0] = 1'b0; zs[0] = 1'b1; exp_c[0] = 16'h0800;
    ops[1] = 4'h7; cs[1] = 1'b1; zs[1] = 1'b0; exp_c[1] = 16'h0802;
    ops[2] = 4'h8; cs[2] = 1'b1; zs[2] = 1'b0; exp_c[2] = 16'h0800;
    ops[3] = 4'h8; cs[3] = 1'b0; zs[3] = 1'b1; exp_c[3] = 16'h0802;
    for (int k = 0; k < 4; k++) begin
      bus.ir_op  = ops[k];
      bus.flag_c = cs[k];
      bus.flag_z = zs[k];
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (bus.stage !== 3'd2 || bus.ctrl !== exp_c[k]) begin
        bad++;
        $display("FAIL jump%0d_t2: stage=%0d ctrl=%h want 2/%h", k, bus.stage, bus.ctrl, exp_c[k]);
      end
      total++;
      if (bus.instr_done !== 1'b1) begin
        bad++;
        $display("FAIL jump%0d_done: got %b want 1", k, bus.instr_done);
      end
      @(negedge clk);
      #1;
      total++;
      if (bus.stage !== 3'd0) begin
        bad++;
        $display("FAIL jump%0d_wrap: stage=%0d want 0", k, bus.stage);
      end
    end
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
  endtask

  task automatic test_single_step();
    int nz;
    int dones;
    bus.ir_op     = 4'h2;
    bus.step_mode = 1'b1;
    bus.step      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd0 || bus.ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL step_idle: stage=%0d ctrl=%h want 0/0000", bus.stage, bus.ctrl);
    end
    bus.step = 1'b1;
    nz = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.ctrl !== 16'h0000) nz++;
      @(negedge clk);
    end
    total++;
    if (nz != 1 || bus.stage !== 3'd1) begin
      bad++;
      $display("FAIL step_held: nonzero=%0d stage=%0d want 1/1", nz, bus.stage);
    end
    nz    = 0;
    dones = 0;
    bus.step = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.step = 1'b1;
      #1;
      if (bus.ctrl !== 16'h0000) nz++;
      if (bus.instr_done === 1'b1) dones++;
      @(negedge clk);
      bus.step = 1'b0;
      #1;
      total++;
      if (bus.ctrl !== 16'h0000 || bus.instr_done !== 1'b0) begin
        bad++;
        $display("FAIL step_low%0d: ctrl=%h done=%b want 0000/0", i, bus.ctrl, bus.instr_done);
      end
      @(negedge clk);
    end
    total++;
    if (nz != 4 || dones != 1 || bus.stage !== 3'd0) begin
      bad++;
      $display("FAIL step_toggle: nonzero=%0d dones=%0d stage=%0d want 4/1/0", nz, dones, bus.stage);
    end
    bus.step_mode = 1'b0;
  endtask

  task automatic test_halt();
    int viol;
    bus.ir_op = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd2 || bus.ctrl !== 16'h8000) begin
      bad++;
      $display("FAIL halt_t2: stage=%0d ctrl=%h want 2/8000", bus.stage, bus.ctrl);
    end
    @(negedge clk);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      bus.step      = i[0];
      bus.step_mode = i[2];
      #1;
      if (bus.halted !== 1'b1 || bus.ctrl !== 16'h0000 ||
          bus.instr_done !== 1'b0 || bus.stage !== 3'd0) viol++;
      @(negedge clk);
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL halt_hold: violating cycles=%0d want 0", viol);
    end
    bus.step      = 1'b0;
    bus.step_mode = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_clear: halted=%b want 0", bus.halted);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.stage !== 3'd0 || bus.ctrl !== 16'h4004) begin
      bad++;
      $display("FAIL halt_restart: stage=%0d ctrl=%h want 0/4004", bus.stage, bus.ctrl);
    end
  endtask

  task automatic test_reset_mid();
    bus.ir_op = 4'h4;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd3) begin
      bad++;
      $display("FAIL sta_reach_t3: stage=%0d want 3", bus.stage);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.ctrl !== 16'h0000) begin
      bad++;
      $display("FAIL sta_no_ri: ctrl=%h want 0000", bus.ctrl);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus.stage !== 3'd0 || bus.ctrl !== 16'h4004) begin
      bad++;
      $display("FAIL sta_restart: stage=%0d ctrl=%h want 0/4004", bus.stage, bus.ctrl);
    end
    @(negedge clk);
  endtask

  task automatic test_undefined();
    // Entered at T1 after test_reset_mid; run one full undefined instruction from T0.
    bus.ir_op = 4'hB;
    @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd0 || bus.ctrl !== 16'h4004 || bus.instr_done !== 1'b0) begin
      bad++;
      $display("FAIL undef_t0: stage=%0d ctrl=%h done=%b want 0/4004/0",
               bus.stage, bus.ctrl, bus.instr_done);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd1 || bus.ctrl !== 16'h1408 || bus.instr_done !== 1'b1) begin
      bad++;
      $display("FAIL undef_t1: stage=%0d ctrl=%h done=%b want 1/1408/1",
               bus.stage, bus.ctrl, bus.instr_done);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.stage !== 3'd0) begin
      bad++;
      $display("FAIL undef_wrap: stage=%0d want 0", bus.stage);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_sub();
    test_jumps();
    test_single_step();
    test_halt();
    test_reset_mid();
    test_undefined();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
